// File: rtl/pll_drp_pkg.sv
// Shared types and constants for the PLLE2_ADV DRP reconfiguration sequencer.
package pll_drp_pkg;

    localparam int DRP_ADDR_W = 7;
    localparam int DRP_DATA_W = 16;

    typedef enum logic [3:0] {
        IDLE,
        HOLD_RST,
        WAIT_CMD,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        RELEASE,
        WAIT_LOCK
    } pll_drp_state_e;

    localparam logic [DRP_ADDR_W-1:0] CLKOUT0_REG1  = 7'h08;
    localparam logic [DRP_ADDR_W-1:0] CLKOUT0_REG2  = 7'h09;
    localparam logic [DRP_ADDR_W-1:0] CLKFBOUT_REG1 = 7'h14;
    localparam logic [DRP_ADDR_W-1:0] CLKFBOUT_REG2 = 7'h15;

    // Mask bit 1 keeps the bit read back from the PLL, 0 takes the new data bit.
    function automatic logic [DRP_DATA_W-1:0] drp_merge(
        input logic [DRP_DATA_W-1:0] old_val,
        input logic [DRP_DATA_W-1:0] mask,
        input logic [DRP_DATA_W-1:0] data
    );
        return (old_val & mask) | (data & ~mask);
    endfunction

endpackage

// File: rtl/pll_drp_ctrl.sv
// PLLE2_ADV reconfiguration sequencer: masked DRP read-modify-writes under PLL reset.
// Define PLL_DRP_LOCK_TIMEOUT_EN to bound the wait for LOCKED and report err_o.
module pll_drp_ctrl
    import pll_drp_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES = 4,
    parameter int unsigned LOCK_TIMEOUT    = 65535
) (
    input  logic                  IO_CLK,
    input  logic                  IO_RST_N,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [DRP_ADDR_W-1:0] cmd_addr_i,
    input  logic [DRP_DATA_W-1:0] cmd_mask_i,
    input  logic [DRP_DATA_W-1:0] cmd_data_i,
    input  logic                  cmd_last_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  pll_rst_o,
    output logic [DRP_ADDR_W-1:0] pll_daddr_o,
    output logic                  pll_den_o,
    output logic                  pll_dwe_o,
    output logic [DRP_DATA_W-1:0] pll_di_o,
    input  logic [DRP_DATA_W-1:0] pll_do_i,
    input  logic                  pll_drdy_i,
    input  logic                  pll_locked_i,
    output logic                  rst_sys_n_o
);

    localparam int HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_HOLD_CYCLES - 1);

    pll_drp_state_e        r_state;
    logic [HOLD_W-1:0]     r_hold_cnt;
    logic [DRP_ADDR_W-1:0] r_addr;
    logic [DRP_DATA_W-1:0] r_mask;
    logic [DRP_DATA_W-1:0] r_data;
    logic                  r_last;
    logic                  r_cmd_ready;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_pll_rst;
    logic [DRP_ADDR_W-1:0] r_daddr;
    logic                  r_den;
    logic                  r_dwe;
    logic [DRP_DATA_W-1:0] r_di;
    logic                  r_rst_sys_n;
`ifdef PLL_DRP_LOCK_TIMEOUT_EN
    localparam logic [15:0] LOCK_LAST = 16'(LOCK_TIMEOUT - 1);
    logic [15:0]           r_lock_cnt;
    logic                  r_err;
`endif

    logic w_xfer;
    assign w_xfer = cmd_valid_i & r_cmd_ready;

    // NOTE: every output is a flop written on the same edge as the state change
    // into the state that owns it, so DEN/DWE/ready line up cycle-exact with state.
    always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
        if (!IO_RST_N) begin
            r_state     <= IDLE;
            r_hold_cnt  <= '0;
            r_addr      <= '0;
            r_mask      <= '0;
            r_data      <= '0;
            r_last      <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pll_rst   <= 1'b0;
            r_daddr     <= '0;
            r_den       <= 1'b0;
            r_dwe       <= 1'b0;
            r_di        <= '0;
            r_rst_sys_n <= 1'b0;
`ifdef PLL_DRP_LOCK_TIMEOUT_EN
            r_lock_cnt  <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_done      <= 1'b0;
            r_rst_sys_n <= pll_locked_i & (r_state == IDLE) & ~r_pll_rst;
            case (r_state)
                IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_xfer) begin
                        r_addr      <= cmd_addr_i;
                        r_mask      <= cmd_mask_i;
                        r_data      <= cmd_data_i;
                        r_last      <= cmd_last_i;
                        r_cmd_ready <= 1'b0;
                        r_pll_rst   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_hold_cnt  <= HOLD_LOAD;
`ifdef PLL_DRP_LOCK_TIMEOUT_EN
                        r_err       <= 1'b0;
`endif
                        r_state     <= HOLD_RST;
                    end
                end
                HOLD_RST: begin
                    if (r_hold_cnt == '0) begin
                        r_den   <= 1'b1;
                        r_dwe   <= 1'b0;
                        r_daddr <= r_addr;
                        r_state <= RD_REQ;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
                    end
                end
                WAIT_CMD: begin
                    if (w_xfer) begin
                        r_addr      <= cmd_addr_i;
                        r_mask      <= cmd_mask_i;
                        r_data      <= cmd_data_i;
                        r_last      <= cmd_last_i;
                        r_cmd_ready <= 1'b0;
                        r_den       <= 1'b1;
                        r_dwe       <= 1'b0;
                        r_daddr     <= cmd_addr_i;
                        r_state     <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    r_den   <= 1'b0;
                    r_state <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (pll_drdy_i) begin
                        r_di    <= drp_merge(pll_do_i, r_mask, r_data);
                        r_den   <= 1'b1;
                        r_dwe   <= 1'b1;
                        r_state <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    r_den   <= 1'b0;
                    r_dwe   <= 1'b0;
                    r_state <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (pll_drdy_i) begin
                        if (r_last) begin
                            r_pll_rst <= 1'b0;
                            r_state   <= RELEASE;
                        end else begin
                            r_cmd_ready <= 1'b1;
                            r_state     <= WAIT_CMD;
                        end
                    end
                end
                RELEASE: begin
`ifdef PLL_DRP_LOCK_TIMEOUT_EN
                    r_lock_cnt <= '0;
`endif
                    r_state <= WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (pll_locked_i) begin
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
`ifdef PLL_DRP_LOCK_TIMEOUT_EN
                    else if (r_lock_cnt == LOCK_LAST) begin
                        r_err       <= 1'b1;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + 16'd1;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef PLL_DRP_LOCK_TIMEOUT_EN
    assign err_o = r_err;
`else
    logic w_unused_lock_timeout;
    assign w_unused_lock_timeout = |LOCK_TIMEOUT;
    assign err_o = 1'b0;
`endif

    assign cmd_ready_o = r_cmd_ready;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign pll_rst_o   = r_pll_rst;
    assign pll_daddr_o = r_daddr;
    assign pll_den_o   = r_den;
    assign pll_dwe_o   = r_dwe;
    assign pll_di_o    = r_di;
    assign rst_sys_n_o = r_rst_sys_n;

endmodule

// File: tb/tb_pll_drp_ctrl.sv
// Directed bench for pll_drp_ctrl with a behavioural DRP port and LOCKED model.
module tb_pll_drp_ctrl;
    import pll_drp_pkg::*;

    localparam int H = 4;

    logic        IO_CLK = 1'b0;
    logic        IO_RST_N = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [6:0]  cmd_addr_i = '0;
    logic [15:0] cmd_mask_i = '0;
    logic [15:0] cmd_data_i = '0;
    logic        cmd_last_i = 1'b0;
    logic        busy_o, done_o, err_o, pll_rst_o, pll_den_o, pll_dwe_o, rst_sys_n_o;
    logic [6:0]  pll_daddr_o;
    logic [15:0] pll_di_o;
    logic [15:0] pll_do_i;
    logic        pll_drdy_i;
    logic        pll_locked_i;

    always #5 IO_CLK = ~IO_CLK;

    pll_drp_ctrl #(.RST_HOLD_CYCLES(H), .LOCK_TIMEOUT(100)) dut (
        .IO_CLK(IO_CLK), .IO_RST_N(IO_RST_N),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_addr_i(cmd_addr_i), .cmd_mask_i(cmd_mask_i), .cmd_data_i(cmd_data_i),
        .cmd_last_i(cmd_last_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .pll_rst_o(pll_rst_o), .pll_daddr_o(pll_daddr_o), .pll_den_o(pll_den_o),
        .pll_dwe_o(pll_dwe_o), .pll_di_o(pll_di_o), .pll_do_i(pll_do_i),
        .pll_drdy_i(pll_drdy_i), .pll_locked_i(pll_locked_i), .rst_sys_n_o(rst_sys_n_o)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    // DRP port model: answers each DEN after drdy_delay cycles and logs the access.
    int          drdy_delay = 1;
    logic [15:0] do_val = '0;
    int          spur_seq = 0;
    logic [6:0]  log_addr [64];
    logic        log_we   [64];
    logic [15:0] log_di   [64];
    logic        log_rst  [64];
    int          log_n;

    initial begin : drp_model
        int   spur_seen;
        logic is_wr;
        spur_seen  = 0;
        log_n      = 0;
        pll_drdy_i = 1'b0;
        pll_do_i   = '0;
        forever begin
            @(posedge IO_CLK);
            if (pll_den_o === 1'b1) begin
                log_addr[log_n] = pll_daddr_o;
                log_we[log_n]   = pll_dwe_o;
                log_di[log_n]   = pll_di_o;
                log_rst[log_n]  = pll_rst_o;
                is_wr = pll_dwe_o;
                if (log_n < 63) log_n++;
                #1;
                repeat (drdy_delay - 1) begin
                    @(posedge IO_CLK);
                    #1;
                end
                pll_do_i   = is_wr ? 16'h0000 : do_val;
                pll_drdy_i = 1'b1;
                @(posedge IO_CLK);
                #1;
                pll_drdy_i = 1'b0;
                pll_do_i   = 16'hDEAD;
            end else if (spur_seq != spur_seen) begin
                spur_seen = spur_seq;
                #1;
                pll_do_i   = 16'h5555;
                pll_drdy_i = 1'b1;
                @(posedge IO_CLK);
                #1;
                pll_drdy_i = 1'b0;
            end
        end
    end

    // LOCKED model: locks 3 cycles after RST falls, can be held off or dropped for 3 cycles.
    int drop_seq = 0;
    bit hold_unlock = 1'b0;

    initial begin : lock_model
        int cnt, drop_seen, drop_left;
        cnt = 0;
        drop_seen = 0;
        drop_left = 0;
        pll_locked_i = 1'b0;
        forever begin
            @(posedge IO_CLK);
            #1;
            if (pll_rst_o) cnt = 0;
            else if (cnt < 3) cnt++;
            if (drop_seq != drop_seen) begin
                drop_seen = drop_seq;
                drop_left = 3;
            end
            if (drop_left != 0) begin
                pll_locked_i = 1'b0;
                drop_left--;
            end else begin
                pll_locked_i = (cnt >= 3) && !hold_unlock;
            end
        end
    end

    // DEN must be a single-cycle pulse, only under PLL reset, never alongside ready.
    int viol = 0;
    initial begin : den_monitor
        logic prev;
        prev = 1'b0;
        forever begin
            @(posedge IO_CLK);
            if (pll_den_o === 1'b1 && (prev || !pll_rst_o || cmd_ready_o)) viol++;
            if (pll_dwe_o === 1'b1 && pll_den_o !== 1'b1) viol++;
            prev = pll_den_o;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

    typedef struct {
        logic [6:0]  addr;
        logic [15:0] mask;
        logic [15:0] data;
        logic [15:0] do_val;
        logic [15:0] exp_di;
    } vec_t;

    task automatic send_cmd(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d,
                            input logic l);
        int n;
        n = 0;
        @(negedge IO_CLK);
        while (cmd_ready_o !== 1'b1 && n < 200) begin
            @(negedge IO_CLK);
            n++;
        end
        check("send_ready", 32'(cmd_ready_o), 1);
        cmd_valid_i = 1'b1;
        cmd_addr_i  = a;
        cmd_mask_i  = m;
        cmd_data_i  = d;
        cmd_last_i  = l;
        @(posedge IO_CLK);
        #1;
        cmd_valid_i = 1'b0;
        cmd_addr_i  = ~a;
        cmd_mask_i  = ~m;
        cmd_data_i  = ~d;
        cmd_last_i  = ~l;
        check("ready_drops", 32'(cmd_ready_o), 0);
    endtask

    task automatic wait_den(output int n);
        n = 0;
        do begin
            @(negedge IO_CLK);
            n++;
        end while (pll_den_o !== 1'b1 && n < 200);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(negedge IO_CLK);
            n++;
        end while (cmd_ready_o !== 1'b1 && n < 200);
        check("wait_ready", 32'(cmd_ready_o), 1);
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        do begin
            @(negedge IO_CLK);
            n++;
        end while (done_o !== 1'b1 && n < budget);
        check("done_pulse", 32'(done_o), 1);
    endtask

    task automatic run_single(input vec_t v, input int exp_wr_gap);
        int n, base;
        base   = log_n;
        do_val = v.do_val;
        send_cmd(v.addr, v.mask, v.data, 1'b1);
        check("busy_set", 32'(busy_o), 1);
        check("pll_rst_set", 32'(pll_rst_o), 1);
        wait_den(n);
        check("rd_latency", 32'(n), 32'(H + 1));
        check("rd_dwe_low", 32'(pll_dwe_o), 0);
        check("rst_sys_low_in_seq", 32'(rst_sys_n_o), 0);
        wait_den(n);
        check("wr_latency", 32'(n), 32'(exp_wr_gap));
        check("wr_dwe_high", 32'(pll_dwe_o), 1);
        wait_done(200, n);
        check("pll_rst_released", 32'(pll_rst_o), 0);
        check("busy_cleared", 32'(busy_o), 0);
        check("rst_sys_at_done", 32'(rst_sys_n_o), 0);
        @(negedge IO_CLK);
        check("rst_sys_rises", 32'(rst_sys_n_o), 1);
        check("access_count", 32'(log_n - base), 2);
        check("rd_addr", 32'(log_addr[base]), 32'(v.addr));
        check("rd_we", 32'(log_we[base]), 0);
        check("wr_addr", 32'(log_addr[base + 1]), 32'(v.addr));
        check("wr_we", 32'(log_we[base + 1]), 1);
        check("wr_di", 32'(log_di[base + 1]), 32'(v.exp_di));
    endtask

    initial begin : main
        vec_t        vecs [5];
        vec_t        vx;
        int          n, base, lows, bad;
        logic [6:0]  exp_a [3];
        logic [15:0] exp_d [3];
        logic        lk [8];
        logic        rs [8];

        vecs[0] = '{CLKOUT0_REG1,  16'h1000, 16'h0618, 16'hFFFF, 16'h1618};
        vecs[1] = '{CLKOUT0_REG2,  16'hFFFF, 16'h1234, 16'hA5A5, 16'hA5A5};
        vecs[2] = '{CLKFBOUT_REG1, 16'h0000, 16'h1234, 16'hA5A5, 16'h1234};
        vecs[3] = '{CLKFBOUT_REG2, 16'hFF00, 16'h00CC, 16'h1234, 16'h12CC};
        vecs[4] = '{7'h7F,         16'h0F0F, 16'hFFFF, 16'h0000, 16'hF0F0};

        #1;
        check("reset_all_zero", 32'({cmd_ready_o, busy_o, done_o, err_o, pll_rst_o, pll_daddr_o,
                                     pll_den_o, pll_dwe_o, pll_di_o, rst_sys_n_o}), 0);
        repeat (3) @(negedge IO_CLK);
        IO_RST_N = 1'b1;
        @(negedge IO_CLK);
        check("ready_after_reset", 32'(cmd_ready_o), 1);
        repeat (6) @(negedge IO_CLK);
        check("rst_sys_idle_locked", 32'(rst_sys_n_o), 1);

        for (int i = 0; i < 5; i++) run_single(vecs[i], 2);

        // Three-command burst with gaps while waiting for the next command.
        base   = log_n;
        do_val = 16'h5A5A;
        exp_a  = '{CLKOUT0_REG1, CLKOUT0_REG2, CLKFBOUT_REG1};
        exp_d  = '{16'h5A5A, 16'hAB5A, 16'h5123};
        send_cmd(CLKOUT0_REG1, 16'hFFFF, 16'h1111, 1'b0);
        wait_ready(n);
        check("burst_busy_1", 32'(busy_o), 1);
        check("burst_pll_rst_1", 32'(pll_rst_o), 1);
        repeat (5) @(negedge IO_CLK);
        check("burst_ready_held", 32'(cmd_ready_o), 1);
        send_cmd(CLKOUT0_REG2, 16'h00FF, 16'hAB00, 1'b0);
        wait_ready(n);
        check("burst_pll_rst_2", 32'(pll_rst_o), 1);
        repeat (5) @(negedge IO_CLK);
        check("burst_no_done", 32'(done_o), 0);
        send_cmd(CLKFBOUT_REG1, 16'hF000, 16'h0123, 1'b1);
        wait_done(200, n);
        check("burst_access_count", 32'(log_n - base), 6);
        for (int i = 0; i < 3; i++) begin
            check("burst_rd_addr", 32'(log_addr[base + 2*i]), 32'(exp_a[i]));
            check("burst_rd_we", 32'(log_we[base + 2*i]), 0);
            check("burst_wr_addr", 32'(log_addr[base + 2*i + 1]), 32'(exp_a[i]));
            check("burst_wr_we", 32'(log_we[base + 2*i + 1]), 1);
            check("burst_wr_di", 32'(log_di[base + 2*i + 1]), 32'(exp_d[i]));
            check("burst_rst_rd", 32'(log_rst[base + 2*i]), 1);
            check("burst_rst_wr", 32'(log_rst[base + 2*i + 1]), 1);
        end
        repeat (2) @(negedge IO_CLK);

        // Spurious DRDY while idle, then a slow DRP answer.
        spur_seq++;
        repeat (4) @(negedge IO_CLK);
        check("spur_busy", 32'(busy_o), 0);
        check("spur_ready", 32'(cmd_ready_o), 1);
        check("spur_pll_rst", 32'(pll_rst_o), 0);
        check("spur_rst_sys", 32'(rst_sys_n_o), 1);
        drdy_delay = 10;
        vx = '{CLKFBOUT_REG2, 16'h00FF, 16'hAA00, 16'h0F0F, 16'hAA0F};
        run_single(vx, 11);
        drdy_delay = 1;

        // LOCKED drops for 3 cycles while idle.
        repeat (2) @(negedge IO_CLK);
        drop_seq++;
        for (int i = 0; i < 8; i++) begin
            @(negedge IO_CLK);
            lk[i] = pll_locked_i;
            rs[i] = rst_sys_n_o;
        end
        lows = 0;
        bad  = 0;
        for (int i = 0; i < 8; i++) if (!rs[i]) lows++;
        for (int i = 1; i < 8; i++) if (rs[i] !== lk[i-1]) bad++;
        check("lockdrop_first_sample_high", 32'(rs[0]), 1);
        check("lockdrop_low_cycles", 32'(lows), 3);
        check("lockdrop_follow_delay1", 32'(bad), 0);
        repeat (3) @(negedge IO_CLK);

        hold_unlock = 1'b1;
`ifdef PLL_DRP_LOCK_TIMEOUT_EN
        send_cmd(CLKOUT0_REG1, 16'hFFFF, 16'h0000, 1'b1);
        wait_done(300, n);
        check("timeout_latency", 32'(n), 32'(H + 106));
        check("timeout_err", 32'(err_o), 1);
        check("timeout_busy", 32'(busy_o), 0);
        check("timeout_pll_rst", 32'(pll_rst_o), 0);
        @(negedge IO_CLK);
        check("timeout_rst_sys", 32'(rst_sys_n_o), 0);
        check("timeout_err_sticky", 32'(err_o), 1);
        send_cmd(CLKOUT0_REG1, 16'hFFFF, 16'h0000, 1'b1);
        check("err_cleared_on_cmd", 32'(err_o), 0);
        hold_unlock = 1'b0;
        wait_done(200, n);
        check("relock_err", 32'(err_o), 0);
`else
        send_cmd(CLKOUT0_REG1, 16'hFFFF, 16'h0000, 1'b1);
        n = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge IO_CLK);
            if (done_o) n++;
        end
        check("no_timeout_done", 32'(n), 0);
        check("no_timeout_busy", 32'(busy_o), 1);
        check("no_timeout_err", 32'(err_o), 0);
        hold_unlock = 1'b0;
        wait_done(200, n);
`endif
        repeat (3) @(negedge IO_CLK);

        // Asynchronous reset while waiting for the read DRDY.
        drdy_delay = 20;
        send_cmd(CLKFBOUT_REG2, 16'h0000, 16'hBEEF, 1'b1);
        wait_den(n);
        check("rst_mid_rd_latency", 32'(n), 32'(H + 1));
        repeat (3) @(negedge IO_CLK);
        IO_RST_N = 1'b0;
        #1;
        check("rst_mid_all_zero", 32'({cmd_ready_o, busy_o, done_o, err_o, pll_rst_o, pll_daddr_o,
                                       pll_den_o, pll_dwe_o, pll_di_o, rst_sys_n_o}), 0);
        repeat (2) @(negedge IO_CLK);
        IO_RST_N = 1'b1;
        repeat (30) @(negedge IO_CLK);
        drdy_delay = 1;
        check("rst_mid_idle", 32'(busy_o), 0);
        check("rst_mid_rst_sys", 32'(rst_sys_n_o), 1);
        vx = '{CLKFBOUT_REG2, 16'hFF00, 16'h0033, 16'hC3C3, 16'hC333};
        run_single(vx, 2);

        check("den_protocol_violations", 32'(viol), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
